cpu: RTL and testbench
======================

// Module: cpu
// PURPOSE
//  - 19-bit multi-cycle load/store CPU core: 8x19-bit register file, 19-bit PC, single shared memory bus.
//  - Fetches and executes ALU, branch and memory instructions; top-level compute block driving external RAM.
// PARAMETERS
//  - RESET_PC  19'd0  PC value loaded on reset
// PORTS
//  - clk        in     1   system clock, all state on rising edge
//  - rst_n      in     1   reset, asynchronous, active-low
//  - pc         out   19   current program counter
//  - data_bus   inout 19   memory data; driven by cpu only while mem_write=1, else 19'bz
//  - address    out   19   memory address
//  - mem_read   out    1   read strobe; memory returns data on data_bus same cycle
//  - mem_write  out    1   write strobe; data_bus carries store data same cycle
// BEHAVIOUR
//  - Internal names fixed for hierarchical access: register_file[0:7] (19b each), ir (19b).
//  - Format: opcode=ir[18:14], rd=ir[13:11], rs1=ir[10:8], rs2=ir[7:5]; addr11=ir[10:0] zero-extended to 19b.
//  - Opcodes: 00000 ADD rd=rs1+rs2; 00001 SUB rd=rs1-rs2; 00010 AND; 00011 OR; 00100 XOR;
//    00101 NOT rd=~rs1; 00110 SHL rd=rs1<<rs2[4:0]; 00111 SHR (logical); 01000 INC rd=rd+1; 01001 DEC rd=rd-1;
//    01010 JMP pc=addr11; 01011 BEQ if rd==rs1 pc=ir[7:0]; 01100 LD rd=mem[addr11]; 01101 ST mem[addr11]=rd;
//    01110 BNE if rd!=rs1 pc=ir[7:0]; 11111 HLT; all other opcodes = NOP.
//  - Arithmetic modulo 2^19 (wrap, no flags); shift amounts >=19 yield 0.
//  - FSM: BOOT -> FETCH -> EXEC -> (MEM for LD/ST) -> FETCH; HLT -> HALT (held until reset).
//  - BOOT: one cycle after reset release, all strobes 0.
//  - FETCH: address=pc, mem_read=1; at edge ir<=data_bus, pc<=pc+1, -> EXEC.
//  - EXEC: ALU write to register_file[rd]; branches update pc; non-memory ops -> FETCH.
//  - MEM (LD): address=addr11, mem_read=1; at edge register_file[rd]<=data_bus.
//  - MEM (ST): address=addr11, mem_write=1, data_bus=register_file[rd]; no register change.
//  - Latency: ALU/branch/NOP 2 cycles, LD/ST 3 cycles.
//  - mem_read and mem_write never both 1; outputs decoded from state/ir.
//  - Reset: pc=RESET_PC, ir=0, all registers 0, state=BOOT, address=0, mem_read=0, mem_write=0, data_bus=Z.
//  - Reset mid-instruction: abandons operation immediately; partially completed store not retried.
//  - PC wraps 19'h7FFFF -> 0; rd==rs1 aliasing legal (reads pre-write value).
// CONFIGURATION
//  - CPU_MULDIV_EN defined: 10000 MUL rd=(rs1*rs2)[18:0]; 10001 DIV rd=rs1/rs2 (unsigned), div-by-0 gives 19'h7FFFF.
//  - CPU_MULDIV_EN undefined: 10000/10001 are NOPs, no multiplier/divider synthesized.
// STRUCTURE
//  - cpu_pkg: opcode localparams, FSM state enum, DATA_W=19, REG_AW=3 constants.
//  - Sub-module cpu_alu: combinational (opcode, a, b) -> 19b result; contains the CPU_MULDIV_EN logic.
// TESTING
//  - Reset: rst_n=0 -> pc=0, mem_read=mem_write=0, data_bus=Z, register_file all 0.
//  - ADD: R2=10, R3=5, ir=ADD rd1 rs2 rs3 in EXEC -> R1=15 after 1 edge.
//  - AND: R2=19'b1010, R3=19'b1100, AND rd1 rs2 rs3 -> R1=19'b1000.
//  - LD: LD rd0 addr 0, bus returns 42 -> address=0, mem_read=1 in MEM, R0=42.
//  - ST: R1=99, ST rd1 addr 0 -> mem_write=1, address=0, data_bus=99 for one cycle.
//  - Wrap/branch: R1=19'h7FFFF, INC rd1 -> R1=0; BEQ R1,R0 target 8 -> pc=8; HLT -> pc frozen.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared widths, opcode encodings and FSM states for the 19-bit multi-cycle cpu core.
// Opcodes 10000/10001 (MUL/DIV) are only executed when CPU_MULDIV_EN is defined.
package cpu_pkg;
  localparam int DATA_W = 19;
  localparam int REG_AW = 3;
  localparam int OP_W   = 5;

  localparam logic [OP_W-1:0] OP_ADD = 5'b00000;
  localparam logic [OP_W-1:0] OP_SUB = 5'b00001;
  localparam logic [OP_W-1:0] OP_AND = 5'b00010;
  localparam logic [OP_W-1:0] OP_OR  = 5'b00011;
  localparam logic [OP_W-1:0] OP_XOR = 5'b00100;
  localparam logic [OP_W-1:0] OP_NOT = 5'b00101;
  localparam logic [OP_W-1:0] OP_SHL = 5'b00110;
  localparam logic [OP_W-1:0] OP_SHR = 5'b00111;
  localparam logic [OP_W-1:0] OP_INC = 5'b01000;
  localparam logic [OP_W-1:0] OP_DEC = 5'b01001;
  localparam logic [OP_W-1:0] OP_JMP = 5'b01010;
  localparam logic [OP_W-1:0] OP_BEQ = 5'b01011;
  localparam logic [OP_W-1:0] OP_LD  = 5'b01100;
  localparam logic [OP_W-1:0] OP_ST  = 5'b01101;
  localparam logic [OP_W-1:0] OP_BNE = 5'b01110;
  localparam logic [OP_W-1:0] OP_MUL = 5'b10000;
  localparam logic [OP_W-1:0] OP_DIV = 5'b10001;
  localparam logic [OP_W-1:0] OP_HLT = 5'b11111;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_FETCH,
    ST_EXEC,
    ST_MEM,
    ST_HALT
  } state_t;
endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU for the cpu core; wr_en flags opcodes that write rd.
// MUL/DIV hardware exists only when CPU_MULDIV_EN is defined, otherwise those opcodes are NOPs.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0]   opcode,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              wr_en
);

  always_comb begin
    result = '0;
    wr_en  = 1'b1;
    case (opcode)
      OP_ADD: result = a + b;
      OP_SUB: result = a - b;
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
      // Shift amount is rs2[4:0]; anything past the word width clears the result.
      OP_SHL: result = (b[4:0] >= 5'd19) ? '0 : (a << b[4:0]);
      OP_SHR: result = (b[4:0] >= 5'd19) ? '0 : (a >> b[4:0]);
      OP_INC: result = a + DATA_W'(1);
      OP_DEC: result = a - DATA_W'(1);
`ifdef CPU_MULDIV_EN
      OP_MUL: result = DATA_W'(a * b);
      OP_DIV: result = (b == '0) ? '1 : (a / b);
`else
`endif
      default: wr_en = 1'b0;
    endcase
  end

endmodule

// File: rtl/cpu.sv
// 19-bit multi-cycle load/store cpu: BOOT -> FETCH -> EXEC -> (MEM) -> FETCH over one shared bus.
// Optional MUL/DIV opcodes are enabled by defining CPU_MULDIV_EN (handled inside cpu_alu).
module cpu
  import cpu_pkg::*;
#(
  parameter logic [18:0] RESET_PC = 19'd0
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [18:0] pc,
  inout  logic [18:0] data_bus,
  output logic [18:0] address,
  output logic        mem_read,
  output logic        mem_write
);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   pc_q, pc_d;
  logic [DATA_W-1:0]   ir, ir_d;
  logic [DATA_W-1:0]   register_file [0:(2**REG_AW)-1];

  logic [OP_W-1:0]     opcode;
  logic [REG_AW-1:0]   rd, rs1, rs2;
  logic [DATA_W-1:0]   addr11;
  logic [DATA_W-1:0]   rd_val, rs1_val, rs2_val;
  logic [DATA_W-1:0]   alu_a, alu_result;
  logic                alu_wr_en;
  logic                rf_we;
  logic [DATA_W-1:0]   rf_wdata;

  assign opcode  = ir[18:14];
  assign rd      = ir[13:11];
  assign rs1     = ir[10:8];
  assign rs2     = ir[7:5];
  assign addr11  = {8'b0, ir[10:0]};
  assign rd_val  = register_file[rd];
  assign rs1_val = register_file[rs1];
  assign rs2_val = register_file[rs2];

  // INC/DEC operate on rd itself rather than rs1.
  assign alu_a = (opcode == OP_INC || opcode == OP_DEC) ? rd_val : rs1_val;

  cpu_alu u_alu (
    .opcode (opcode),
    .a      (alu_a),
    .b      (rs2_val),
    .result (alu_result),
    .wr_en  (alu_wr_en)
  );

  assign pc       = pc_q;
  assign data_bus = mem_write ? rd_val : 'z;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir;
    rf_we     = 1'b0;
    rf_wdata  = alu_result;
    address   = '0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      ST_FETCH: begin
        address  = pc_q;
        mem_read = 1'b1;
        ir_d     = data_bus;
        pc_d     = pc_q + DATA_W'(1);
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        rf_we   = alu_wr_en;
        case (opcode)
          OP_JMP: pc_d = addr11;
          OP_BEQ: if (rd_val == rs1_val) pc_d = {11'b0, ir[7:0]};
          OP_BNE: if (rd_val != rs1_val) pc_d = {11'b0, ir[7:0]};
          OP_LD, OP_ST: state_d = ST_MEM;
          OP_HLT: state_d = ST_HALT;
          default: ;
        endcase
      end
      ST_MEM: begin
        address = addr11;
        state_d = ST_FETCH;
        if (opcode == OP_LD) begin
          mem_read = 1'b1;
          rf_we    = 1'b1;
          rf_wdata = data_bus;
        end else begin
          mem_write = 1'b1;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      ir      <= '0;
      for (int i = 0; i < 2**REG_AW; i++) begin
        register_file[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir      <= ir_d;
      if (rf_we) begin
        register_file[rd] <= rf_wdata;
      end
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: a program of directed instructions, expected stores queued up front
// and matched by a bus monitor; register/pc state checked at reset, halt and async reset.
module tb_cpu;

  typedef struct {
    logic [18:0] addr;
    logic [18:0] data;
    int          cyc;
  } store_t;

  logic        clk;
  logic        rst_n;
  logic [18:0] pc;
  wire  [18:0] data_bus;
  logic [18:0] address;
  logic        mem_read;
  logic        mem_write;

  logic [18:0] mem [0:2047];
  store_t      sb [$];
  int          tests_run;
  int          tests_failed;
  int          cyc;

  localparam logic [4:0] ADD = 5'b00000, SUB = 5'b00001, AND = 5'b00010, OR = 5'b00011;
  localparam logic [4:0] XOR = 5'b00100, NOT = 5'b00101, SHL = 5'b00110, SHR = 5'b00111;
  localparam logic [4:0] INC = 5'b01000, DEC = 5'b01001, JMP = 5'b01010, BEQ = 5'b01011;
  localparam logic [4:0] LD  = 5'b01100, ST  = 5'b01101, BNE = 5'b01110, MUL = 5'b10000;
  localparam logic [4:0] DIV = 5'b10001, UND = 5'b10010, HLT = 5'b11111;

  cpu dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .data_bus  (data_bus),
    .address   (address),
    .mem_read  (mem_read),
    .mem_write (mem_write)
  );

  assign data_bus = mem_read ? ((address < 19'd2048) ? mem[address[10:0]] : 19'd0) : 'z;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [18:0] enc_r(logic [4:0] op, int rd, int rs1, int rs2);
    return {op, 3'(rd), 3'(rs1), 3'(rs2), 5'b0};
  endfunction

  function automatic logic [18:0] enc_m(logic [4:0] op, int rd, int addr);
    return {op, 3'(rd), 11'(addr)};
  endfunction

  function automatic logic [18:0] enc_b(logic [4:0] op, int rd, int rs1, int tgt);
    return {op, 3'(rd), 3'(rs1), 8'(tgt)};
  endfunction

  task automatic check_output(input string name, input logic [18:0] actual,
                              input logic [18:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic expect_store(input int addr, input logic [18:0] data, input int at_cyc);
    store_t e;
    e.addr = 19'(addr);
    e.data = data;
    e.cyc  = at_cyc;
    sb.push_back(e);
  endtask

  // Loads the program and data image; each ST expected to execute queues its address/data.
  task automatic apply_stimulus();
    for (int i = 0; i < 2048; i++) mem[i] = enc_m(ST, 0, 12'h2FF);
    mem[11'h100] = 19'd10;
    mem[11'h101] = 19'd5;
    mem[11'h102] = 19'b1010;
    mem[11'h103] = 19'b1100;
    mem[11'h104] = 19'd42;
    mem[11'h105] = 19'h7FFFF;
    mem[11'h106] = 19'd3;
    mem[11'h107] = 19'd18;
    mem[11'h108] = 19'd19;

    mem[0]  = enc_m(LD, 2, 12'h100);
    mem[1]  = enc_m(LD, 3, 12'h101);
    mem[2]  = enc_r(ADD, 1, 2, 3);
    mem[3]  = enc_m(ST, 1, 12'h200);  expect_store(12'h200, 19'd15, 11);
    mem[4]  = enc_r(SUB, 4, 3, 2);
    mem[5]  = enc_m(ST, 4, 12'h201);  expect_store(12'h201, 19'h7FFFB, 16);
    mem[6]  = enc_m(LD, 2, 12'h102);
    mem[7]  = enc_m(LD, 3, 12'h103);
    mem[8]  = enc_r(AND, 1, 2, 3);
    mem[9]  = enc_m(ST, 1, 12'h202);  expect_store(12'h202, 19'b1000, -1);
    mem[10] = enc_r(OR, 1, 2, 3);
    mem[11] = enc_m(ST, 1, 12'h203);  expect_store(12'h203, 19'b1110, -1);
    mem[12] = enc_r(XOR, 1, 2, 3);
    mem[13] = enc_m(ST, 1, 12'h204);  expect_store(12'h204, 19'b0110, -1);
    mem[14] = enc_r(NOT, 1, 2, 0);
    mem[15] = enc_m(ST, 1, 12'h205);  expect_store(12'h205, 19'h7FFF5, -1);
    mem[16] = enc_m(LD, 3, 12'h106);
    mem[17] = enc_r(SHL, 1, 2, 3);
    mem[18] = enc_m(ST, 1, 12'h206);  expect_store(12'h206, 19'd80, -1);
    mem[19] = enc_r(SHR, 1, 2, 3);
    mem[20] = enc_m(ST, 1, 12'h207);  expect_store(12'h207, 19'd1, -1);
    mem[21] = enc_m(LD, 5, 12'h105);
    mem[22] = enc_m(LD, 3, 12'h107);
    mem[23] = enc_r(SHR, 1, 5, 3);
    mem[24] = enc_m(ST, 1, 12'h208);  expect_store(12'h208, 19'd1, -1);
    mem[25] = enc_m(LD, 3, 12'h108);
    mem[26] = enc_r(SHL, 1, 5, 3);
    mem[27] = enc_m(ST, 1, 12'h209);  expect_store(12'h209, 19'd0, -1);
    mem[28] = enc_m(LD, 0, 12'h104);
    mem[29] = enc_m(ST, 0, 12'h20A);  expect_store(12'h20A, 19'd42, -1);
    mem[30] = enc_m(LD, 1, 12'h105);
    mem[31] = enc_r(INC, 1, 0, 0);
    mem[32] = enc_m(ST, 1, 12'h20B);  expect_store(12'h20B, 19'd0, -1);
    mem[33] = enc_r(DEC, 1, 0, 0);
    mem[34] = enc_m(ST, 1, 12'h20C);  expect_store(12'h20C, 19'h7FFFF, -1);
    mem[35] = enc_r(INC, 1, 0, 0);
    mem[36] = enc_b(BEQ, 1, 6, 40);
    mem[40] = enc_b(BNE, 1, 6, 48);
    mem[41] = enc_r(ADD, 0, 0, 0);
    mem[42] = enc_m(ST, 0, 12'h20D);  expect_store(12'h20D, 19'd84, -1);
    mem[43] = enc_b(BNE, 0, 6, 46);
    mem[46] = enc_m(JMP, 0, 49);
    mem[49] = enc_r(MUL, 2, 2, 3);
    mem[50] = enc_m(ST, 2, 12'h20E);
    mem[51] = enc_r(DIV, 4, 2, 6);
    mem[52] = enc_m(ST, 4, 12'h20F);
`ifdef CPU_MULDIV_EN
    expect_store(12'h20E, 19'd190, -1);
    expect_store(12'h20F, 19'h7FFFF, -1);
`else
    expect_store(12'h20E, 19'd10, -1);
    expect_store(12'h20F, 19'h7FFFB, -1);
`endif
    mem[53] = enc_r(UND, 0, 0, 0);
    mem[54] = enc_m(ST, 0, 12'h210);  expect_store(12'h210, 19'd84, -1);
    mem[55] = enc_m(HLT, 0, 0);
  endtask

  // Bus monitor: every store strobe is matched against the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_read && mem_write) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL strobe_exclusive: mem_read=1 mem_write=1 expected one at most");
      end
      if (mem_write) begin
        if (sb.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("[TB] FAIL unexpected_store: addr %h data %h, none expected", address, data_bus);
        end else begin
          store_t e;
          e = sb.pop_front();
          check_output("store_addr", address, e.addr);
          check_output("store_data", data_bus, e.data);
          if (e.cyc >= 0) check_output("store_cycle", 19'(cyc), 19'(e.cyc));
        end
      end
    end
  end

  initial begin
    int stable;
    tests_run    = 0;
    tests_failed = 0;
    rst_n        = 1'b0;
    apply_stimulus();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_pc", pc, 19'd0);
    check_output("reset_mem_read", 19'(mem_read), 19'd0);
    check_output("reset_mem_write", 19'(mem_write), 19'd0);
    check_output("reset_address", address, 19'd0);
    check_output("reset_ir", dut.ir, 19'd0);
    for (int i = 0; i < 8; i++) check_output("reset_reg", dut.register_file[i], 19'd0);

    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("boot_mem_read", 19'(mem_read), 19'd0);
    check_output("boot_pc", pc, 19'd0);
    @(negedge clk);
    check_output("fetch_mem_read", 19'(mem_read), 19'd1);
    check_output("fetch_address", address, 19'd0);

    stable = 0;
    for (int i = 0; i < 2000 && stable < 5; i++) begin
      @(negedge clk);
      if (pc == 19'd56 && !mem_read && !mem_write) stable++;
      else stable = 0;
    end
    check_output("halt_reached", 19'(stable >= 5), 19'd1);

    repeat (20) @(negedge clk);
    check_output("halt_pc_frozen", pc, 19'd56);
    check_output("halt_no_read", 19'(mem_read), 19'd0);
    check_output("stores_pending", 19'(sb.size()), 19'd0);
    check_output("final_r0", dut.register_file[0], 19'd84);
    check_output("final_r1", dut.register_file[1], 19'd0);
    check_output("final_r5", dut.register_file[5], 19'h7FFFF);

    #2 rst_n = 1'b0;
    #1;
    check_output("async_reset_pc", pc, 19'd0);
    check_output("async_reset_r0", dut.register_file[0], 19'd0);
    check_output("async_reset_read", 19'(mem_read), 19'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
